// File: rtl/p2_bus_arb_pkg.sv
// Shared definitions for the P2 bus arbiter: bus widths, FSM encoding, master ids
// and a small width helper used to size the GO-state counter.
package p2_defs;
    localparam int P2_AW = 23;
    localparam int P2_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GO    = 2'd2,
        ST_DONE  = 2'd3
    } p2_state_e;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Bits needed to hold the range 0..max_val (never less than one).
    function automatic int cnt_width(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w = w + 1;
        return w;
    endfunction
endpackage

// File: rtl/p2_bus_arb_rr_arb.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the master
// that was not served last.
module p2_rr_arb
    import p2_defs::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt_valid,
    output logic gnt_id
);
    always_comb begin
        gnt_valid = req0 | req1;
        if (req0 && req1) begin
            gnt_id = (last == M0) ? M1 : M0;
        end else begin
            gnt_id = req1 ? M1 : M0;
        end
    end
endmodule

// File: rtl/p2_bus_arb.sv
// P2 bus arbiter and cycle sequencer: shares the bus between m0 and m1 and runs one
// go_n-strobed transfer per grant. Define P2_TIMEOUT_EN to add the stuck-slave timeout.
module p2_bus_arb
    import p2_defs::*;
#(
    parameter int WAIT_SETTLE = 1
`ifdef P2_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic [P2_AW-1:0] m0_addr,
    input  logic             m0_rw_n,
    input  logic             m0_wel_n,
    input  logic             m0_weu_n,
    input  logic [P2_DW-1:0] m0_wdata,
    output logic             m0_ack,
    output logic [P2_DW-1:0] m0_rdata,
    output logic             m0_err,
    input  logic             m1_req,
    input  logic [P2_AW-1:0] m1_addr,
    input  logic             m1_rw_n,
    input  logic             m1_wel_n,
    input  logic             m1_weu_n,
    input  logic [P2_DW-1:0] m1_wdata,
    output logic             m1_ack,
    output logic [P2_DW-1:0] m1_rdata,
    output logic             m1_err,
    output logic [P2_AW-1:0] p2_addr,
    output logic             p2_rw_n,
    output logic             p2_wel_n,
    output logic             p2_weu_n,
    output logic             p2_go_n,
    input  logic             p2_wait_n,
    output logic [P2_DW-1:0] p2_datao,
    input  logic [P2_DW-1:0] p2_datai
);
`ifdef P2_TIMEOUT_EN
    localparam int CNT_MAX = (TIMEOUT_CYCLES > WAIT_SETTLE) ? TIMEOUT_CYCLES : WAIT_SETTLE;
`else
    localparam int CNT_MAX = WAIT_SETTLE;
`endif
    localparam int CNT_W = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] SETTLE_VAL = CNT_W'(WAIT_SETTLE);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);
`ifdef P2_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);
`endif

    logic [P2_AW-1:0] addr_v  [2];
    logic             rw_n_v  [2];
    logic             wel_n_v [2];
    logic             weu_n_v [2];
    logic [P2_DW-1:0] wdata_v [2];

    assign addr_v[0]  = m0_addr;
    assign addr_v[1]  = m1_addr;
    assign rw_n_v[0]  = m0_rw_n;
    assign rw_n_v[1]  = m1_rw_n;
    assign wel_n_v[0] = m0_wel_n;
    assign wel_n_v[1] = m1_wel_n;
    assign weu_n_v[0] = m0_weu_n;
    assign weu_n_v[1] = m1_weu_n;
    assign wdata_v[0] = m0_wdata;
    assign wdata_v[1] = m1_wdata;

    p2_state_e        state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [P2_AW-1:0] addr_q, addr_d;
    logic             rw_n_q, rw_n_d;
    logic [P2_DW-1:0] datao_q, datao_d;
    logic             lat_wel_n_q, lat_wel_n_d;
    logic             lat_weu_n_q, lat_weu_n_d;
    logic             go_n_q, go_n_d;
    logic             wel_n_q, wel_n_d;
    logic             weu_n_q, weu_n_d;
    logic             to_done;
    logic             timeout_hit;
    logic             arb_valid, arb_id;

    p2_rr_arb u_rr_arb (
        .req0      (m0_req),
        .req1      (m1_req),
        .last      (last_q),
        .gnt_valid (arb_valid),
        .gnt_id    (arb_id)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rw_n_d      = rw_n_q;
        datao_d     = datao_q;
        lat_wel_n_d = lat_wel_n_q;
        lat_weu_n_d = lat_weu_n_q;
        to_done     = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d       = arb_id;
                    addr_d      = addr_v[arb_id];
                    rw_n_d      = rw_n_v[arb_id];
                    datao_d     = wdata_v[arb_id];
                    lat_wel_n_d = wel_n_v[arb_id];
                    lat_weu_n_d = weu_n_v[arb_id];
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_GO;
            end
            ST_GO: begin
                if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
                // Slave wait is only trusted once its decode has had time to settle.
                if (cnt_q >= SETTLE_VAL && p2_wait_n) begin
                    to_done = 1'b1;
                    state_d = ST_DONE;
                end
`ifdef P2_TIMEOUT_EN
                else if (cnt_q == TIMEOUT_VAL) begin
                    to_done     = 1'b1;
                    timeout_hit = 1'b1;
                    state_d     = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                last_d  = gnt_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus strobes are derived from the next state so they leave a flop cleanly.
    always_comb begin
        go_n_d  = (state_d != ST_GO);
        wel_n_d = 1'b1;
        weu_n_d = 1'b1;
        if (state_d == ST_GO && !rw_n_d) begin
            wel_n_d = lat_wel_n_d;
            weu_n_d = lat_weu_n_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= M0;
            last_q      <= M1;
            cnt_q       <= '0;
            addr_q      <= '0;
            rw_n_q      <= 1'b1;
            datao_q     <= '0;
            lat_wel_n_q <= 1'b1;
            lat_weu_n_q <= 1'b1;
            go_n_q      <= 1'b1;
            wel_n_q     <= 1'b1;
            weu_n_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rw_n_q      <= rw_n_d;
            datao_q     <= datao_d;
            lat_wel_n_q <= lat_wel_n_d;
            lat_weu_n_q <= lat_weu_n_d;
            go_n_q      <= go_n_d;
            wel_n_q     <= wel_n_d;
            weu_n_q     <= weu_n_d;
        end
    end

    logic [1:0]       ack_out;
    logic [1:0]       err_out;
    logic [P2_DW-1:0] rdata_out [2];

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        logic             ack_q, ack_d;
        logic             err_q, err_d;
        logic [P2_DW-1:0] rdata_q, rdata_d;

        // Read data is taken on the edge that ends GO so it lines up with the ack.
        always_comb begin
            ack_d   = to_done && (gnt_q == 1'(gi));
            err_d   = ack_d && timeout_hit;
            rdata_d = rdata_q;
            if (ack_d) begin
                if (timeout_hit) begin
                    rdata_d = '1;
                end else if (rw_n_q) begin
                    rdata_d = p2_datai;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                ack_q   <= 1'b0;
                err_q   <= 1'b0;
                rdata_q <= '0;
            end else begin
                ack_q   <= ack_d;
                err_q   <= err_d;
                rdata_q <= rdata_d;
            end
        end

        assign ack_out[gi]   = ack_q;
        assign err_out[gi]   = err_q;
        assign rdata_out[gi] = rdata_q;
    end

    assign m0_ack   = ack_out[0];
    assign m1_ack   = ack_out[1];
    assign m0_err   = err_out[0];
    assign m1_err   = err_out[1];
    assign m0_rdata = rdata_out[0];
    assign m1_rdata = rdata_out[1];

    assign p2_addr  = addr_q;
    assign p2_rw_n  = rw_n_q;
    assign p2_datao = datao_q;
    assign p2_go_n  = go_n_q;
    assign p2_wel_n = wel_n_q;
    assign p2_weu_n = weu_n_q;
endmodule

// File: tb/tb_p2_bus_arb.sv
// Directed + randomized bench for p2_bus_arb with a behavioural slave and a
// round-robin/latency reference model kept in the bench.
module tb_p2_bus_arb;
    localparam int WS = 1;
    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_rw_n, m0_wel_n, m0_weu_n, m0_ack, m0_err;
    logic [22:0] m0_addr;
    logic [15:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_rw_n, m1_wel_n, m1_weu_n, m1_ack, m1_err;
    logic [22:0] m1_addr;
    logic [15:0] m1_wdata, m1_rdata;
    logic [22:0] p2_addr;
    logic        p2_rw_n, p2_wel_n, p2_weu_n, p2_go_n, p2_wait_n;
    logic [15:0] p2_datao, p2_datai;

    int checks = 0;
    int errors = 0;

    p2_bus_arb #(
        .WAIT_SETTLE (WS)
`ifdef P2_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TO)
`endif
    ) dut (
        .clk (clk), .reset (reset),
        .m0_req (m0_req), .m0_addr (m0_addr), .m0_rw_n (m0_rw_n), .m0_wel_n (m0_wel_n),
        .m0_weu_n (m0_weu_n), .m0_wdata (m0_wdata), .m0_ack (m0_ack), .m0_rdata (m0_rdata),
        .m0_err (m0_err),
        .m1_req (m1_req), .m1_addr (m1_addr), .m1_rw_n (m1_rw_n), .m1_wel_n (m1_wel_n),
        .m1_weu_n (m1_weu_n), .m1_wdata (m1_wdata), .m1_ack (m1_ack), .m1_rdata (m1_rdata),
        .m1_err (m1_err),
        .p2_addr (p2_addr), .p2_rw_n (p2_rw_n), .p2_wel_n (p2_wel_n), .p2_weu_n (p2_weu_n),
        .p2_go_n (p2_go_n), .p2_wait_n (p2_wait_n), .p2_datao (p2_datao), .p2_datai (p2_datai)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural slave: holds wait_n low for slave_wait cycles after go_n falls.
    int          slave_wait = 0;
    logic [15:0] slave_data = 16'h0;
    int          go_len = 0;
    int          last_go_len = 0;
    logic [22:0] rec_addr = '0;
    logic        rec_rw = 1'b0, rec_wel = 1'b0, rec_weu = 1'b0;
    logic [15:0] rec_datao = '0;

    initial begin
        p2_wait_n = 1'b1;
        p2_datai  = 16'h0;
        forever begin
            @(negedge clk);
            if (p2_go_n === 1'b0) begin
                if (go_len == 0) begin
                    rec_addr  = p2_addr;
                    rec_rw    = p2_rw_n;
                    rec_wel   = p2_wel_n;
                    rec_weu   = p2_weu_n;
                    rec_datao = p2_datao;
                end
                p2_wait_n = (go_len >= slave_wait);
                p2_datai  = slave_data;
                go_len++;
            end else begin
                if (go_len != 0) last_go_len = go_len;
                go_len    = 0;
                p2_wait_n = 1'($urandom);
                p2_datai  = 16'($urandom);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic        model_last;
    logic [15:0] model_rdata [2];
    logic [22:0] ex_addr  [2];
    logic        ex_rw    [2];
    logic        ex_wel   [2];
    logic        ex_weu   [2];
    logic [15:0] ex_wdata [2];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input int w);
        return 3 + ((w > WS) ? w : WS);
    endfunction

    function automatic int pick(input bit r0, input bit r1);
        if (r0 && r1) return (model_last == 1'b1) ? 0 : 1;
        return r1 ? 1 : 0;
    endfunction

    task automatic drive(input int m, input logic [22:0] a, input logic rw, input logic wl,
                         input logic wu, input logic [15:0] wd);
        ex_addr[m] = a; ex_rw[m] = rw; ex_wel[m] = wl; ex_weu[m] = wu; ex_wdata[m] = wd;
        if (m == 0) begin
            m0_addr = a; m0_rw_n = rw; m0_wel_n = wl; m0_weu_n = wu; m0_wdata = wd; m0_req = 1'b1;
        end else begin
            m1_addr = a; m1_rw_n = rw; m1_wel_n = wl; m1_weu_n = wu; m1_wdata = wd; m1_req = 1'b1;
        end
    endtask

    task automatic drive_rand(input int m);
        drive(m, 23'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
    endtask

    task automatic drop(input int m);
        if (m == 0) m0_req = 1'b0;
        else m1_req = 1'b0;
    endtask

    task automatic wait_ack(input int bound, output int who, output int n, output bit err_seen);
        who = -1;
        n = 0;
        err_seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            n++;
            if (m0_err === 1'b1 || m1_err === 1'b1) err_seen = 1'b1;
            if (m0_ack === 1'b1 || m1_ack === 1'b1) begin
                who = (m0_ack === 1'b1 && m1_ack === 1'b1) ? 2 : ((m1_ack === 1'b1) ? 1 : 0);
                break;
            end
        end
    endtask

    task automatic serve(input int m, input int w, input int exp_n, input bit exp_to,
                         input bit drop_req, input logic [15:0] data);
        int who, n;
        bit es;
        slave_wait = w;
        slave_data = data;
        wait_ack(64, who, n, es);
        chk("ack_master", who, m);
        chk("ack_latency", n, exp_n);
        chk("go_low_cycles", last_go_len, exp_to ? (TO + 1) : (((w > WS) ? w : WS) + 1));
        chk("bus_addr", rec_addr, ex_addr[m]);
        chk("bus_rw_n", rec_rw, ex_rw[m]);
        chk("bus_datao", rec_datao, ex_wdata[m]);
        chk("bus_wel_n", rec_wel, ex_rw[m] ? 1'b1 : ex_wel[m]);
        chk("bus_weu_n", rec_weu, ex_rw[m] ? 1'b1 : ex_weu[m]);
        if (exp_to) model_rdata[m] = 16'hFFFF;
        else if (ex_rw[m]) model_rdata[m] = data;
        chk("m0_rdata", m0_rdata, model_rdata[0]);
        chk("m1_rdata", m1_rdata, model_rdata[1]);
        chk("err", (m == 1) ? m1_err : m0_err, exp_to);
        model_last = (m == 1);
        if (drop_req) drop(m);
        $display("xfer m%0d addr=%h rw_n=%0d wait=%0d latency=%0d rdata0=%h rdata1=%h",
                 m, ex_addr[m], ex_rw[m], w, n, m0_rdata, m1_rdata);
        step();
        chk("ack_pulse", {m1_ack, m0_ack}, 2'b00);
    endtask

    initial begin
        int  who, n, seen, acks, w1, w2, first, pat;
        bit  es, r0, r1;
        reset = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_rw_n = 1'b1; m0_wel_n = 1'b1; m0_weu_n = 1'b1; m0_wdata = '0;
        m1_req = 1'b0; m1_addr = '0; m1_rw_n = 1'b1; m1_wel_n = 1'b1; m1_weu_n = 1'b1; m1_wdata = '0;
        model_last = 1'b1;
        model_rdata[0] = 16'h0;
        model_rdata[1] = 16'h0;
        repeat (3) step();

        chk("rst_go_n", p2_go_n, 1'b1);
        chk("rst_wel_n", p2_wel_n, 1'b1);
        chk("rst_weu_n", p2_weu_n, 1'b1);
        chk("rst_rw_n", p2_rw_n, 1'b1);
        chk("rst_addr", p2_addr, 23'h0);
        chk("rst_datao", p2_datao, 16'h0);
        chk("rst_acks", {m1_ack, m0_ack}, 2'b00);
        chk("rst_errs", {m1_err, m0_err}, 2'b00);
        chk("rst_rdata0", m0_rdata, 16'h0);
        chk("rst_rdata1", m1_rdata, 16'h0);
        reset = 1'b0;
        step();

        // m0 read, no wait states
        drive(0, 23'h000010, 1'b1, 1'b1, 1'b1, 16'h0);
        serve(0, 0, lat(0), 1'b0, 1'b1, 16'h1234);

        // m1 write, lower byte only
        drive(1, 23'h700000, 1'b0, 1'b0, 1'b1, 16'hA5A5);
        serve(1, 0, lat(0), 1'b0, 1'b1, 16'($urandom));

        // both held: strict alternation
        drive_rand(0);
        drive_rand(1);
        for (int i = 0; i < 4; i++) begin
            first = pick(1'b1, 1'b1);
            serve(first, 0, lat(0), 1'b0, 1'b0, 16'($urandom));
        end
        drop(0);
        drop(1);

        // long slave wait
        drive(1, 23'($urandom), 1'b1, 1'b1, 1'b1, 16'h0);
        serve(1, 5, lat(5), 1'b0, 1'b1, 16'($urandom));

        // request withdrawn during ISSUE still completes
        drive(0, 23'($urandom), 1'b0, 1'b0, 1'b0, 16'($urandom));
        step();
        drop(0);
        serve(0, 0, lat(0) - 1, 1'b0, 1'b1, 16'($urandom));

        // randomized request patterns
        for (int it = 0; it < 16; it++) begin
            pat = $urandom_range(1, 3);
            r0 = pat[0];
            r1 = pat[1];
            if (r0) drive_rand(0);
            if (r1) drive_rand(1);
            first = pick(r0, r1);
            w1 = $urandom_range(0, 4);
            serve(first, w1, lat(w1), 1'b0, 1'b1, 16'($urandom));
            if (r0 && r1) begin
                w2 = $urandom_range(0, 4);
                serve(1 - first, w2, lat(w2), 1'b0, 1'b1, 16'($urandom));
            end
        end

        // reset while GO is active
        drive(0, 23'($urandom), 1'b1, 1'b1, 1'b1, 16'h0);
        slave_wait = 3;
        seen = 0;
        for (int i = 0; i < 8 && seen == 0; i++) begin
            step();
            if (p2_go_n === 1'b0) seen = 1;
        end
        chk("go_seen_before_reset", seen, 1);
        reset = 1'b1;
        drop(0);
        step();
        chk("rst_mid_go_n", p2_go_n, 1'b1);
        chk("rst_mid_acks", {m1_ack, m0_ack}, 2'b00);
        chk("rst_mid_errs", {m1_err, m0_err}, 2'b00);
        reset = 1'b0;
        model_last = 1'b1;
        model_rdata[0] = 16'h0;
        model_rdata[1] = 16'h0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m0_ack === 1'b1 || m1_ack === 1'b1 || p2_go_n !== 1'b1) acks++;
        end
        chk("post_reset_quiet", acks, 0);
        chk("post_reset_rdata0", m0_rdata, 16'h0);
        chk("post_reset_rdata1", m1_rdata, 16'h0);
        drive_rand(0);
        drive_rand(1);
        first = pick(1'b1, 1'b1);
        serve(first, 1, lat(1), 1'b0, 1'b1, 16'($urandom));
        serve(1 - first, 2, lat(2), 1'b0, 1'b1, 16'($urandom));

        // slave stuck busy
        drive(1, 23'($urandom), 1'b1, 1'b1, 1'b1, 16'h0);
`ifdef P2_TIMEOUT_EN
        serve(1, 1000, 3 + TO, 1'b1, 1'b1, 16'($urandom));
`else
        slave_wait = 1000;
        wait_ack(40, who, n, es);
        chk("stuck_no_ack", who, -1);
        chk("stuck_no_err", es, 1'b0);
        chk("stuck_go_low", p2_go_n, 1'b0);
        $display("xfer m1 stuck slave, ack after %0d cycles: %0d", n, who);
        reset = 1'b1;
        drop(1);
        step();
        step();
        reset = 1'b0;
        model_last = 1'b1;
        model_rdata[0] = 16'h0;
        model_rdata[1] = 16'h0;
        chk("stuck_reset_go_n", p2_go_n, 1'b1);
`endif
        step();
        drive_rand(1);
        serve(1, 0, lat(0), 1'b0, 1'b1, 16'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
